// File: rtl/bridge_pkg.sv
// Shared types and default address map for the parametrised data-side system bridge.
// Slot order is DM (0), TC1 (1), TC2 (2), INTGEN (3).
package bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } bridge_state_e;

  localparam logic [31:0] DM_BASE      = 32'h0000_0000;
  localparam logic [31:0] DM_LIMIT     = 32'h0000_2fff;
  localparam logic [31:0] TC1_BASE     = 32'h0000_7f00;
  localparam logic [31:0] TC1_LIMIT    = 32'h0000_7f0b;
  localparam logic [31:0] TC2_BASE     = 32'h0000_7f10;
  localparam logic [31:0] TC2_LIMIT    = 32'h0000_7f1b;
  localparam logic [31:0] INTGEN_BASE  = 32'h0000_7f20;
  localparam logic [31:0] INTGEN_LIMIT = 32'h0000_7f23;

  localparam logic [127:0] DEF_DEV_BASE  = {INTGEN_BASE, TC2_BASE, TC1_BASE, DM_BASE};
  localparam logic [127:0] DEF_DEV_LIMIT = {INTGEN_LIMIT, TC2_LIMIT, TC1_LIMIT, DM_LIMIT};
  localparam logic [3:0]   DEF_WORD_ONLY = 4'b0110;

  function automatic int slot_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bridge_addr_decode.sv
// Combinational priority decoder: maps a byte address to the lowest matching
// device window and flags partial writes to word-only windows.
module bridge_addr_decode
  import bridge_pkg::*;
#(
  parameter int                 NDEV      = 4,
  parameter logic [NDEV*32-1:0] DEV_BASE  = DEF_DEV_BASE,
  parameter logic [NDEV*32-1:0] DEV_LIMIT = DEF_DEV_LIMIT,
  parameter logic [NDEV-1:0]    WORD_ONLY = DEF_WORD_ONLY,
  parameter int                 SLOT_W    = slot_width(NDEV)
) (
  input  logic [31:0]       addr,
  input  logic [3:0]        byteen,
  output logic              hit,
  output logic [SLOT_W-1:0] slot,
  output logic [31:0]       offset,
  output logic              illegal_wr
);

  logic [31:0] off_k_s;

  // Scan from the top slot down so the lowest matching window wins; the
  // window test is done on the wrapped offset so a zero base needs no compare.
  always_comb begin
    hit        = 1'b0;
    slot       = {SLOT_W{1'b0}};
    offset     = 32'h0000_0000;
    illegal_wr = 1'b0;
    off_k_s    = 32'h0000_0000;
    for (int k = NDEV - 1; k >= 0; k--) begin
      off_k_s = addr - DEV_BASE[k*32 +: 32];
      if (off_k_s <= (DEV_LIMIT[k*32 +: 32] - DEV_BASE[k*32 +: 32])) begin
        hit        = 1'b1;
        slot       = k[SLOT_W-1:0];
        offset     = off_k_s;
        illegal_wr = WORD_ONLY[k] && (byteen != 4'b0000) && (byteen != 4'b1111);
      end else begin
        hit        = hit;
      end
    end
  end

endmodule

// File: rtl/sys_bridge_n.sv
// Data-side system bridge: decodes CPU accesses into NDEV device windows, runs a
// registered request/ready handshake with timeout, and reports bus errors.
module sys_bridge_n
  import bridge_pkg::*;
#(
  parameter int                 NDEV      = 4,
  parameter logic [NDEV*32-1:0] DEV_BASE  = DEF_DEV_BASE,
  parameter logic [NDEV*32-1:0] DEV_LIMIT = DEF_DEV_LIMIT,
  parameter logic [NDEV-1:0]    WORD_ONLY = DEF_WORD_ONLY,
  parameter int                 TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [31:0]       cpu_addr,
  input  logic [3:0]        cpu_byteen,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,
  output logic [31:0]       err_addr,
  output logic [NDEV-1:0]   dev_sel,
  output logic [NDEV-1:0]   dev_we,
  output logic [31:0]       dev_addr,
  output logic [3:0]        dev_byteen,
  output logic [31:0]       dev_wdata,
  input  logic [NDEV*32-1:0] dev_rdata,
  input  logic [NDEV-1:0]   dev_ready
);

  localparam int SLOT_W = slot_width(NDEV);
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  bridge_state_e     state_r, state_nx_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
  logic [SLOT_W-1:0] slot_r, slot_nx_s;
  logic [31:0]       addr_r, addr_nx_s;
  logic [31:0]       dev_addr_r, dev_addr_nx_s;
  logic [3:0]        dev_byteen_r, dev_byteen_nx_s;
  logic [31:0]       dev_wdata_r, dev_wdata_nx_s;
  logic [NDEV-1:0]   dev_sel_r, dev_sel_nx_s;
  logic [NDEV-1:0]   dev_we_r, dev_we_nx_s;
  logic [31:0]       cpu_rdata_r, cpu_rdata_nx_s;
  logic              cpu_err_r, cpu_err_nx_s;
  logic [31:0]       err_addr_r, err_addr_nx_s;

  logic              dec_hit_s;
  logic [SLOT_W-1:0] dec_slot_s;
  logic [31:0]       dec_offset_s;
  logic              dec_illegal_s;
  logic [NDEV-1:0]   dec_onehot_s;

  bridge_addr_decode #(
    .NDEV      (NDEV),
    .DEV_BASE  (DEV_BASE),
    .DEV_LIMIT (DEV_LIMIT),
    .WORD_ONLY (WORD_ONLY),
    .SLOT_W    (SLOT_W)
  ) u_decode (
    .addr       (cpu_addr),
    .byteen     (cpu_byteen),
    .hit        (dec_hit_s),
    .slot       (dec_slot_s),
    .offset     (dec_offset_s),
    .illegal_wr (dec_illegal_s)
  );

  // Expand the decoded slot index to a one-hot select.
  always_comb begin
    dec_onehot_s = {NDEV{1'b0}};
    for (int k = 0; k < NDEV; k++) begin
      dec_onehot_s[k] = (dec_slot_s == k[SLOT_W-1:0]);
    end
  end

  // Next-state and next-register values; every register holds by default.
  always_comb begin
    state_nx_s      = state_r;
    cnt_nx_s        = cnt_r;
    slot_nx_s       = slot_r;
    addr_nx_s       = addr_r;
    dev_addr_nx_s   = dev_addr_r;
    dev_byteen_nx_s = dev_byteen_r;
    dev_wdata_nx_s  = dev_wdata_r;
    dev_sel_nx_s    = dev_sel_r;
    dev_we_nx_s     = dev_we_r;
    cpu_rdata_nx_s  = cpu_rdata_r;
    cpu_err_nx_s    = cpu_err_r;
    err_addr_nx_s   = err_addr_r;
    case (state_r)
      ST_IDLE: begin
        if (cpu_req && dec_hit_s && !dec_illegal_s) begin
          state_nx_s      = ST_ACCESS;
          cnt_nx_s        = {CNT_W{1'b0}};
          slot_nx_s       = dec_slot_s;
          addr_nx_s       = cpu_addr;
          dev_addr_nx_s   = dec_offset_s;
          dev_byteen_nx_s = cpu_byteen;
          dev_wdata_nx_s  = cpu_wdata;
          dev_sel_nx_s    = dec_onehot_s;
          dev_we_nx_s     = dec_onehot_s & {NDEV{cpu_byteen != 4'b0000}};
        end else if (cpu_req) begin
          // Unmapped or illegal: fail without ever touching a slave.
          state_nx_s      = ST_DONE;
          cpu_rdata_nx_s  = 32'h0000_0000;
          cpu_err_nx_s    = 1'b1;
          err_addr_nx_s   = cpu_addr;
        end else begin
          state_nx_s      = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (dev_ready[slot_r]) begin
          state_nx_s      = ST_DONE;
          cpu_rdata_nx_s  = dev_rdata[slot_r*32 +: 32];
          cpu_err_nx_s    = 1'b0;
          dev_sel_nx_s    = {NDEV{1'b0}};
          dev_we_nx_s     = {NDEV{1'b0}};
        end else if (cnt_r == CNT_W'(TIMEOUT)) begin
          state_nx_s      = ST_DONE;
          cpu_rdata_nx_s  = 32'h0000_0000;
          cpu_err_nx_s    = 1'b1;
          err_addr_nx_s   = addr_r;
          dev_sel_nx_s    = {NDEV{1'b0}};
          dev_we_nx_s     = {NDEV{1'b0}};
        end else begin
          cnt_nx_s        = cnt_r + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_nx_s        = ST_IDLE;
      end
      default: begin
        state_nx_s        = ST_IDLE;
        dev_sel_nx_s      = {NDEV{1'b0}};
        dev_we_nx_s       = {NDEV{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      slot_r       <= {SLOT_W{1'b0}};
      addr_r       <= 32'h0000_0000;
      dev_addr_r   <= 32'h0000_0000;
      dev_byteen_r <= 4'b0000;
      dev_wdata_r  <= 32'h0000_0000;
      dev_sel_r    <= {NDEV{1'b0}};
      dev_we_r     <= {NDEV{1'b0}};
      cpu_rdata_r  <= 32'h0000_0000;
      cpu_err_r    <= 1'b0;
      err_addr_r   <= 32'h0000_0000;
    end else begin
      state_r      <= state_nx_s;
      cnt_r        <= cnt_nx_s;
      slot_r       <= slot_nx_s;
      addr_r       <= addr_nx_s;
      dev_addr_r   <= dev_addr_nx_s;
      dev_byteen_r <= dev_byteen_nx_s;
      dev_wdata_r  <= dev_wdata_nx_s;
      dev_sel_r    <= dev_sel_nx_s;
      dev_we_r     <= dev_we_nx_s;
      cpu_rdata_r  <= cpu_rdata_nx_s;
      cpu_err_r    <= cpu_err_nx_s;
      err_addr_r   <= err_addr_nx_s;
    end
  end

  assign cpu_stall  = cpu_req && (state_r != ST_DONE);
  assign cpu_rdata  = cpu_rdata_r;
  assign cpu_err    = cpu_err_r;
  assign err_addr   = err_addr_r;
  assign dev_sel    = dev_sel_r;
  assign dev_we     = dev_we_r;
  assign dev_addr   = dev_addr_r;
  assign dev_byteen = dev_byteen_r;
  assign dev_wdata  = dev_wdata_r;

endmodule

// File: tb/tb_sys_bridge_n.sv
// Directed, table-driven bench for sys_bridge_n with a per-slot ready model
// and hand-written reset sequences.
module tb_sys_bridge_n;

  logic         clk;
  logic         reset;
  logic         cpu_req;
  logic [31:0]  cpu_addr;
  logic [3:0]   cpu_byteen;
  logic [31:0]  cpu_wdata;
  logic         cpu_stall;
  logic [31:0]  cpu_rdata;
  logic         cpu_err;
  logic [31:0]  err_addr;
  logic [3:0]   dev_sel;
  logic [3:0]   dev_we;
  logic [31:0]  dev_addr;
  logic [3:0]   dev_byteen;
  logic [31:0]  dev_wdata;
  logic [127:0] dev_rdata;
  logic [3:0]   dev_ready;

  int checks = 0;
  int errors = 0;

  sys_bridge_n dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_byteen (cpu_byteen),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rdata  (cpu_rdata),
    .cpu_err    (cpu_err),
    .err_addr   (err_addr),
    .dev_sel    (dev_sel),
    .dev_we     (dev_we),
    .dev_addr   (dev_addr),
    .dev_byteen (dev_byteen),
    .dev_wdata  (dev_wdata),
    .dev_rdata  (dev_rdata),
    .dev_ready  (dev_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // delay = ACCESS cycles before ready on the selected slot; 31 = never
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
    int          stalls;
    logic [3:0]  sel;
    logic [3:0]  we;
    int          selc;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_err_addr;
    logic [31:0] exp_dev_addr;
  } vec_t;

  vec_t vecs[12];
  vec_t rec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          stalls;
    int          selc;
    int          cyc;
    logic [3:0]  sel_or;
    logic [3:0]  we_or;
    logic [31:0] last_da;
    logic [31:0] last_wd;
    logic [3:0]  last_be;
    logic        done;
    stalls = 0; selc = 0; cyc = 0; done = 1'b0;
    sel_or = 4'b0000; we_or = 4'b0000;
    last_da = 32'h0; last_wd = 32'h0; last_be = 4'b0000;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = v.addr; cpu_byteen = v.be; cpu_wdata = v.wdata;
    dev_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      dev_rdata[k*32 +: 32] = v.sel[k] ? v.rdata : (32'hBAD0_0000 + 32'(k));
    end
    while (!done && cyc < 40) begin
      #1;
      if (!cpu_stall) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (dev_sel != 4'b0000) begin
          selc++;
          sel_or |= dev_sel;
          we_or  |= dev_we;
          last_da = dev_addr; last_wd = dev_wdata; last_be = dev_byteen;
          // non-selected slots report ready, which must be ignored
          dev_ready = (selc - 1 == v.delay) ? dev_sel : ~dev_sel;
        end else begin
          dev_ready = 4'b1111;
        end
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_done"},    32'(done),   32'd1);
    check({tag, "_stalls"},  32'(stalls), 32'(v.stalls));
    check({tag, "_sel"},     32'(sel_or), 32'(v.sel));
    check({tag, "_we"},      32'(we_or),  32'(v.we));
    check({tag, "_selcyc"},  32'(selc),   32'(v.selc));
    check({tag, "_rdata"},   cpu_rdata,   v.exp_rdata);
    check({tag, "_err"},     32'(cpu_err), 32'(v.exp_err));
    check({tag, "_erraddr"}, err_addr,    v.exp_err_addr);
    check({tag, "_donesel"}, 32'(dev_sel), 32'd0);
    if (v.selc > 0) begin
      check({tag, "_devaddr"}, last_da, v.exp_dev_addr);
      check({tag, "_wdata"},   last_wd, v.wdata);
      check({tag, "_byteen"},  32'(last_be), 32'(v.be));
    end
    cpu_req = 1'b0; dev_ready = 4'b0000;
  endtask

  initial begin
    //            addr          be     wdata         dly rdata         stl sel     we      sc exp_rdata     err   err_addr      dev_addr
    vecs[0]  = '{32'h0000_1004, 4'h0, 32'h0000_0000,  0, 32'hDEAD_BEEF,  2, 4'h1, 4'h0,  1, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 32'h0000_1004};
    vecs[1]  = '{32'h0000_7f04, 4'hF, 32'h0000_0055,  3, 32'h1111_2222,  5, 4'h2, 4'h2,  4, 32'h1111_2222, 1'b0, 32'h0000_0000, 32'h0000_0004};
    vecs[2]  = '{32'h0000_7f10, 4'h1, 32'h0000_00FF,  0, 32'h0000_0000,  1, 4'h0, 4'h0,  0, 32'h0000_0000, 1'b1, 32'h0000_7f10, 32'h0000_0000};
    vecs[3]  = '{32'h0000_5000, 4'h0, 32'h0000_0000,  0, 32'h0000_0000,  1, 4'h0, 4'h0,  0, 32'h0000_0000, 1'b1, 32'h0000_5000, 32'h0000_0000};
    vecs[4]  = '{32'h0000_7f20, 4'h0, 32'h0000_0000, 31, 32'h1234_5678, 17, 4'h8, 4'h0, 16, 32'h0000_0000, 1'b1, 32'h0000_7f20, 32'h0000_0000};
    vecs[5]  = '{32'h0000_7f1b, 4'h0, 32'h0000_0000,  1, 32'hCAFE_0001,  3, 4'h4, 4'h0,  2, 32'hCAFE_0001, 1'b0, 32'h0000_7f20, 32'h0000_000b};
    vecs[6]  = '{32'h0000_7f23, 4'h8, 32'h1200_0000,  0, 32'h0BAD_F00D,  2, 4'h8, 4'h8,  1, 32'h0BAD_F00D, 1'b0, 32'h0000_7f20, 32'h0000_0003};
    vecs[7]  = '{32'h0000_2fff, 4'h0, 32'h0000_0000,  0, 32'h0000_2FFF,  2, 4'h1, 4'h0,  1, 32'h0000_2FFF, 1'b0, 32'h0000_7f20, 32'h0000_2fff};
    vecs[8]  = '{32'h0000_3000, 4'h0, 32'h0000_0000,  0, 32'h0000_0000,  1, 4'h0, 4'h0,  0, 32'h0000_0000, 1'b1, 32'h0000_3000, 32'h0000_0000};
    vecs[9]  = '{32'h0000_7f00, 4'hF, 32'h0000_00AA, 15, 32'h600D_600D, 17, 4'h2, 4'h2, 16, 32'h600D_600D, 1'b0, 32'h0000_3000, 32'h0000_0000};
    vecs[10] = '{32'h0000_7f0c, 4'h0, 32'h0000_0000,  0, 32'h0000_0000,  1, 4'h0, 4'h0,  0, 32'h0000_0000, 1'b1, 32'h0000_7f0c, 32'h0000_0000};
    vecs[11] = '{32'h0000_7f08, 4'h3, 32'h0000_1234,  0, 32'h0000_0000,  1, 4'h0, 4'h0,  0, 32'h0000_0000, 1'b1, 32'h0000_7f08, 32'h0000_0000};

    reset = 1'b0; cpu_req = 1'b0; cpu_addr = 32'h0; cpu_byteen = 4'h0; cpu_wdata = 32'h0;
    dev_rdata = 128'h0; dev_ready = 4'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall",  32'(cpu_stall),  32'd0);
    check("rst_rdata",  cpu_rdata,       32'd0);
    check("rst_err",    32'(cpu_err),    32'd0);
    check("rst_eaddr",  err_addr,        32'd0);
    check("rst_sel",    32'(dev_sel),    32'd0);
    check("rst_we",     32'(dev_we),     32'd0);
    check("rst_byteen", 32'(dev_byteen), 32'd0);
    check("rst_wdata",  dev_wdata,       32'd0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // reset asserted during the 2nd ACCESS cycle of a slot-2 write
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h0000_7f14; cpu_byteen = 4'hF; cpu_wdata = 32'h0000_0077;
    dev_ready = 4'h0;
    @(negedge clk);
    #1;
    check("mid_sel", 32'(dev_sel), 32'h4);
    check("mid_we",  32'(dev_we),  32'h4);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_sel",   32'(dev_sel), 32'd0);
    check("mid_rst_we",    32'(dev_we),  32'd0);
    check("mid_rst_err",   32'(cpu_err), 32'd0);
    check("mid_rst_eaddr", err_addr,     32'd0);
    check("mid_rst_rdata", cpu_rdata,    32'd0);
    cpu_req = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_stall", 32'(cpu_stall), 32'd0);

    // recovery: a fresh slot-2 write must take the minimum two stall cycles
    rec = '{32'h0000_7f14, 4'hF, 32'h0000_0077, 0, 32'h0000_0077, 2, 4'h4, 4'h4, 1,
            32'h0000_0077, 1'b0, 32'h0000_0000, 32'h0000_0004};
    run_vec(rec, "recov");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sys_bridge_n.md
Name: sys_bridge_n

Overview:
Parametrised successor to the CPU system bridge. It decodes CPU data-side accesses into NDEV address windows, which can be DM, timers, the interrupt generator or further peripherals. Unlike a purely combinational bridge, it registers each request, waits for a per-device ready handshake, and registers the read data. It reports unmapped, illegal and timed-out accesses as bus errors. It sits between the M-stage memory interface and all data-side slaves.

Parameters:
NDEV, 4, number of device windows (1..8)
DEV_BASE, {32'h7f20,32'h7f10,32'h7f00,32'h0}, packed NDEV*32 base addresses; slot k occupies bits [32k+31:32k]
DEV_LIMIT, {32'h7f23,32'h7f1b,32'h7f0b,32'h2fff}, packed NDEV*32 inclusive upper addresses
WORD_ONLY, 4'b0110, bit k=1: slot k accepts only full-word writes (byteen 4'b1111)
TIMEOUT, 15, maximum ACCESS cycles without dev_ready before an error; 4-bit counter width derived as $clog2(TIMEOUT+1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset)
cpu_req  in  1  access request; CPU holds it and all request fields stable while cpu_stall=1
cpu_addr  in  32  byte address
cpu_byteen  in  4  write byte enables; 4'b0000 = read
cpu_wdata  in  32  write data
cpu_stall  out  1  CPU must hold the M stage
cpu_rdata  out  32  registered read data, valid in DONE
cpu_err  out  1  bus error flag for the completing access, valid in DONE
err_addr  out  32  address of the most recent errored access (sticky)
dev_sel  out  NDEV  one-hot slot select
dev_we  out  NDEV  one-hot write strobe
dev_addr  out  32  offset address (cpu_addr - base)
dev_byteen  out  4  byte enables to the slave
dev_wdata  out  32  write data to the slave
dev_rdata  in  NDEV*32  packed slave read data
dev_ready  in  NDEV  slave completion handshake

Behaviour:
- Reset (reset==0 at posedge): state IDLE; cpu_rdata=0, cpu_err=0, err_addr=0, timeout counter=0. dev_sel, dev_we, dev_byteen and dev_wdata go to 0. This applies mid-ACCESS too: the in-flight access is abandoned and no strobe is issued the next cycle.
- States: IDLE, ACCESS, DONE.
- Decode is combinational on cpu_addr. Slot k hits when DEV_BASE[k] <= addr <= DEV_LIMIT[k]. When windows overlap, the lowest k wins.
- cpu_stall = cpu_req && state!=DONE. In IDLE, cpu_stall is 0 when cpu_req=0.
- IDLE with cpu_req=1:
  - Normal hit: latch addr, byteen, wdata and the slot index, clear the counter, go to ACCESS.
  - Miss, or a write with byteen!=4'b1111 to a WORD_ONLY slot: go to DONE with cpu_err=1, cpu_rdata=0, err_addr=cpu_addr. No dev_sel is ever asserted.
- ACCESS:
  - dev_sel[k]=1 and dev_we[k]=(byteen!=0), both held every cycle; other slots 0.
  - dev_ready[k]=1: cpu_rdata=dev_rdata[k] (captured for writes too), cpu_err=0, go to DONE.
  - Otherwise the counter increments. When it equals TIMEOUT, go to DONE with cpu_err=1, cpu_rdata=0, err_addr=latched addr. Slot k therefore sees at most TIMEOUT+1 select cycles.
  - dev_ready of non-selected slots is ignored.
- DONE: dev_sel=0, cpu_stall=0. Unconditionally return to IDLE. The same cpu_req is never relaunched, because the CPU advances at the end of DONE.
- Minimum latency is 2 stall cycles: IDLE, then ACCESS with ready, then DONE.
- dev_we is a level strobe. A slave must commit the write exactly once, on the cycle it asserts ready.
- cpu_rdata and cpu_err hold their values until the next DONE or reset. err_addr changes only on an error.
- dev_addr = latched addr - DEV_BASE[k], modulo 2^32.

Decomposition:
- Package bridge_pkg: state enum (IDLE/ACCESS/DONE), TC1/TC2/INTGEN/DM base and limit constants, default WORD_ONLY mask.
- One sub-module, bridge_addr_decode: combinational priority decoder. Inputs: addr, byteen. Outputs: hit, slot index, offset, illegal-write flag.

Test Plan:
- DM read 0x0000_1004, dev_ready[0] in the first ACCESS cycle, dev_rdata[0]=0xDEAD_BEEF -> cpu_stall high for exactly 2 cycles; DONE shows cpu_rdata=0xDEADBEEF, cpu_err=0, dev_addr=0x1004.
- Word write 0x7f04 data 0x55, slot 1 ready after 3 cycles -> dev_sel=4'b0010 and dev_we=4'b0010 held for 4 cycles, dev_addr=0x4, cpu_err=0.
- Byte write (byteen 0001) to 0x7f10 -> no dev_sel at any point; 1 stall cycle, then DONE with cpu_err=1, err_addr=0x7f10.
- Read 0x5000 (unmapped) -> cpu_err=1, cpu_rdata=0, err_addr=0x5000, no dev_sel.
- Read 0x7f20 with dev_ready[3] never asserted -> dev_sel[3] high for 16 cycles; DONE shows cpu_err=1, err_addr=0x7f20; next IDLE is accepted normally.
- reset=0 during the 2nd ACCESS cycle of a slot-2 write -> next cycle state is IDLE, dev_sel=0, dev_we=0, cpu_err=0, err_addr=0.
